// File: rtl/skew_pkg.sv
// Shared types and sizing helpers for the skewed A-side tile loader.
package skew_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        STREAM = 2'd2
    } state_e;

    // Number of diagonal steps needed to drain a rows x k tile.
    function automatic int steps(input int rows, input int k);
        return k + rows - 1;
    endfunction

endpackage

// File: rtl/skew_row_buf.sv
// One tile row: K operand registers written together, read back by a
// signed column index that yields zero (and no hit) when out of range.
module skew_row_buf
    import skew_pkg::*;
#(
    parameter int BITS = 8,
    parameter int K    = 8,
    parameter int IW   = 5
) (
    input  logic                   clk,
    input  logic                   wr_en_i,
    input  logic [K-1:0][BITS-1:0] wr_data_i,
    input  logic [IW-1:0]          rd_idx_i,
    output logic [BITS-1:0]        rd_data_o,
    output logic                   rd_hit_o
);

    logic [BITS-1:0] mem_q [K];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int c = 0; c < K; c++) begin
                mem_q[c] <= wr_data_i[c];
            end
        end
    end

    // Negative indices never match: their sign bit is set, every column's is clear.
    always_comb begin
        rd_data_o = '0;
        rd_hit_o  = 1'b0;
        for (int c = 0; c < K; c++) begin
            if (rd_idx_i == IW'(c)) begin
                rd_data_o = mem_q[c];
                rd_hit_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/skew_tile_loader.sv
// Loads a ROWS x K operand tile row by row, then streams it diagonally
// skewed (lane r delayed r steps) into the west edge of the systolic array.
module skew_tile_loader
    import skew_pkg::*;
#(
    parameter int BITS = 8,
    parameter int ROWS = 8,
    parameter int K    = 8,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en_i,
    input  logic [RW-1:0]             wr_row_i,
    input  logic [K-1:0][BITS-1:0]    wr_data_i,
    input  logic                      start_i,
    input  logic                      en_i,
    output logic                      ready_o,
    output logic                      busy_o,
    output logic [ROWS-1:0][BITS-1:0] aout_o,
    output logic [ROWS-1:0]           aout_vld_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int S  = steps(ROWS, K);
    localparam int CW = $clog2(S + 1);
    localparam int IW = CW + 1;
    localparam logic [CW-1:0] T_LAST = CW'(S - 1);
    localparam logic [RW:0]   ROWS_W = (RW + 1)'(ROWS);

    state_e                   state_q;
    logic [ROWS-1:0]          mask_q;
    logic [CW-1:0]            t_q;
    logic [ROWS-1:0][BITS-1:0] aout_q;
    logic [ROWS-1:0]          vld_q;
    logic                     done_q;
    logic                     err_q;

    logic                     row_ok;
    logic                     wr_ok;
    logic                     err_d;
    logic [ROWS-1:0]          mask_d;
    logic [ROWS-1:0][BITS-1:0] lane_data;
    logic [ROWS-1:0]          lane_hit;

    assign row_ok = ({1'b0, wr_row_i} < ROWS_W);
    assign wr_ok  = wr_en_i && row_ok && (state_q != STREAM);
    assign err_d  = (wr_en_i && (!row_ok || state_q == STREAM))
                  || (start_i && state_q == IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic          row_we;
            logic [IW-1:0] idx;

            assign row_we     = wr_ok && (wr_row_i == RW'(gi));
            assign mask_d[gi] = mask_q[gi] | row_we;
            // Lane gi reads column t - gi; the extra bit keeps negatives distinct.
            assign idx        = IW'(t_q) - IW'(gi);

            skew_row_buf #(
                .BITS (BITS),
                .K    (K),
                .IW   (IW)
            ) u_row_buf (
                .clk       (clk),
                .wr_en_i   (row_we),
                .wr_data_i (wr_data_i),
                .rd_idx_i  (idx),
                .rd_data_o (lane_data[gi]),
                .rd_hit_o  (lane_hit[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            t_q     <= '0;
            aout_q  <= '0;
            vld_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q  <= err_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    mask_q <= mask_d;
                    aout_q <= '0;
                    vld_q  <= '0;
                    if (&mask_d) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    mask_q <= mask_d;
                    aout_q <= '0;
                    vld_q  <= '0;
                    if (start_i) begin
                        state_q <= STREAM;
                        t_q     <= '0;
                    end
                end
                STREAM: begin
                    if (en_i) begin
                        aout_q <= lane_data;
                        vld_q  <= lane_hit;
                        if (t_q == T_LAST) begin
                            done_q  <= 1'b1;
                            mask_q  <= '0;
                            state_q <= IDLE;
                            t_q     <= '0;
                        end else begin
                            t_q <= t_q + CW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o    = (state_q == READY);
    assign busy_o     = (state_q == STREAM);
    assign aout_o     = aout_q;
    assign aout_vld_o = vld_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
